mcpu_control_fsm: RTL and testbench

Main control unit of the multi-cycle CPU. It decodes the instruction opcode, steps the shared datapath through fetch, decode, execute, memory and write-back states, and issues one set of control strobes per cycle. It waits on a memory-ready handshake with a timeout watchdog. It sits between the instruction register and the datapath muxes/enables inside `MultiCycleCPU`, and its state code drives the CPU's `o_state` debug port.

---
 rtl/mcpu_pkg.sv | 58 +++++
 rtl/mcpu_control_fsm_if.sv | 36 +++
 rtl/mcpu_wait_timer.sv | 25 ++
 rtl/mcpu_control_fsm.sv | 161 ++++++++++++++++
 tb/tb_mcpu_control_fsm.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: state codes,
// opcodes, datapath select encodings and the packed control-strobe bundle.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic       mem_err;
    } ctrl_t;

endpackage

// File: rtl/mcpu_control_fsm_if.sv
// Control-unit bundle between the instruction register / memory handshake
// and the datapath; master is the control FSM, slave is the datapath side.
interface mcpu_control_fsm_if;
    logic [5:0] i_opcode;
    logic       i_mem_ready;
    logic [7:0] o_state;
    logic       o_pc_write;
    logic       o_pc_write_cond;
    logic       o_iord;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       o_ir_write;
    logic       o_mem_to_reg;
    logic       o_reg_dst;
    logic       o_reg_write;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_alu_op;
    logic [1:0] o_pc_src;
    logic       o_illegal;
    logic       o_mem_err;

    modport master (
        input  i_opcode, i_mem_ready,
        output o_state, o_pc_write, o_pc_write_cond, o_iord, o_mem_read,
               o_mem_write, o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write,
               o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_src, o_illegal, o_mem_err
    );

    modport slave (
        output i_opcode, i_mem_ready,
        input  o_state, o_pc_write, o_pc_write_cond, o_iord, o_mem_read,
               o_mem_write, o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write,
               o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_src, o_illegal, o_mem_err
    );
endinterface

// File: rtl/mcpu_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles and flags when the count
// equals the configured limit.
module mcpu_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       incr,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (incr)
            count <= count + 8'd1;
    end

    assign expired = (count == limit);

endmodule

// File: rtl/mcpu_control_fsm.sv
// Multi-cycle CPU main control FSM: sequences fetch/decode/execute/memory/
// write-back and issues the per-cycle datapath strobes.
module mcpu_control_fsm
    import mcpu_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mcpu_control_fsm_if.master bus
);

    localparam logic [7:0] LIMIT = 8'(P_TIMEOUT);

    state_t state, next_state;
    ctrl_t  ctrl, ctrl_out;
    logic   ready, wait_state, expired, timeout, timer_clear;

    assign ready      = bus.i_mem_ready;
    assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // Ready in the expiry cycle completes the access instead of aborting it.
    assign timeout    = wait_state && !ready && expired;
    // Clearing on timeout too matters for FETCH, where the abort does not change state.
    assign timer_clear = (next_state != state) || timeout;

    mcpu_wait_timer u_wait_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (timer_clear),
        .incr    (wait_state && !ready),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = ready;
                ctrl.pc_write  = ready;
                if (ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
                case (bus.i_opcode)
                    OP_RTYPE:     next_state = S_RTEX;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default: begin
                        next_state   = S_FETCH;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                if (bus.i_opcode == OP_LW)
                    next_state = S_MEMRD;
                else if (bus.i_opcode == OP_SW)
                    next_state = S_MEMWR;
                else
                    next_state = S_FETCH;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (ready)
                    next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (ready)
                    next_state = S_FETCH;
            end
            S_RTEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                next_state     = S_RTWB;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                next_state     = S_FETCH;
            end
            S_BEQEX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                next_state         = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                next_state     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                next_state     = S_FETCH;
            end
            S_JEX: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
                next_state    = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
        if (timeout) begin
            next_state    = S_FETCH;
            ctrl.mem_err  = 1'b1;
        end
    end

    // Reset masks every output, including the FETCH mem_read.
    assign ctrl_out = i_rst ? '0 : ctrl;

    assign bus.o_state         = i_rst ? '0 : 8'(state);
    assign bus.o_pc_write      = ctrl_out.pc_write;
    assign bus.o_pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.o_iord          = ctrl_out.iord;
    assign bus.o_mem_read      = ctrl_out.mem_read;
    assign bus.o_mem_write     = ctrl_out.mem_write;
    assign bus.o_ir_write      = ctrl_out.ir_write;
    assign bus.o_mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.o_reg_dst       = ctrl_out.reg_dst;
    assign bus.o_reg_write     = ctrl_out.reg_write;
    assign bus.o_alu_src_a     = ctrl_out.alu_src_a;
    assign bus.o_alu_src_b     = ctrl_out.alu_src_b;
    assign bus.o_alu_op        = ctrl_out.alu_op;
    assign bus.o_pc_src        = ctrl_out.pc_src;
    assign bus.o_illegal       = ctrl_out.illegal;
    assign bus.o_mem_err       = ctrl_out.mem_err;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Directed bench for mcpu_control_fsm: one default-timeout instance and one
// with a short timeout, checked cycle by cycle against hand-written tables.
module tb_mcpu_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mcpu_control_fsm_if bus0 ();
    mcpu_control_fsm_if bus1 ();

    mcpu_control_fsm dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0.master)
    );

    mcpu_control_fsm #(.P_TIMEOUT(4)) dut_to (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_src[2], illegal, mem_err}
    function automatic logic [17:0] obs_ctrl(input bit sel);
        if (sel)
            return {bus1.o_pc_write, bus1.o_pc_write_cond, bus1.o_iord, bus1.o_mem_read,
                    bus1.o_mem_write, bus1.o_ir_write, bus1.o_mem_to_reg, bus1.o_reg_dst,
                    bus1.o_reg_write, bus1.o_alu_src_a, bus1.o_alu_src_b, bus1.o_alu_op,
                    bus1.o_pc_src, bus1.o_illegal, bus1.o_mem_err};
        return {bus0.o_pc_write, bus0.o_pc_write_cond, bus0.o_iord, bus0.o_mem_read,
                bus0.o_mem_write, bus0.o_ir_write, bus0.o_mem_to_reg, bus0.o_reg_dst,
                bus0.o_reg_write, bus0.o_alu_src_a, bus0.o_alu_src_b, bus0.o_alu_op,
                bus0.o_pc_src, bus0.o_illegal, bus0.o_mem_err};
    endfunction

    function automatic logic [7:0] obs_state(input bit sel);
        return sel ? bus1.o_state : bus0.o_state;
    endfunction

    // Expected strobes per state; illegal/mem_err bits are added by the caller.
    function automatic logic [17:0] exp_ctrl(input logic [7:0] st, input logic rdy);
        case (st)
            8'd0:  return {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
            8'd1:  return {6'b000000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00};
            8'd2:  return {6'b000000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
            8'd3:  return {6'b001100, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
            8'd4:  return {6'b000000, 4'b1010, 2'b00, 2'b00, 2'b00, 2'b00};
            8'd5:  return {6'b001010, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
            8'd6:  return {6'b000000, 4'b0001, 2'b00, 2'b10, 2'b00, 2'b00};
            8'd7:  return {6'b000000, 4'b0110, 2'b00, 2'b00, 2'b00, 2'b00};
            8'd8:  return {6'b010000, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b00};
            8'd9:  return {6'b000000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
            8'd10: return {6'b000000, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b00};
            8'd11: return {6'b100000, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b00};
            default: return '0;
        endcase
    endfunction

    // Called just after a rising edge; drives ready, checks at the falling edge.
    task automatic do_cycle(input bit sel, input string tag, input logic [7:0] st,
                            input logic rdy, input logic ill, input logic err);
        if (sel) bus1.i_mem_ready = rdy;
        else     bus0.i_mem_ready = rdy;
        @(negedge clk);
        check({tag, " state"}, 32'(obs_state(sel)), 32'(st));
        check({tag, " ctrl"}, 32'(obs_ctrl(sel)), 32'(exp_ctrl(st, rdy) | {16'b0, ill, err}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.i_opcode    = 6'b100011;
        bus0.i_mem_ready = 1'b1;
        bus1.i_opcode    = 6'b000000;
        bus1.i_mem_ready = 1'b1;

        @(negedge clk);
        check("reset state", 32'(bus0.o_state), 32'd0);
        check("reset ctrl", 32'(obs_ctrl(0)), 32'd0);
        check("reset ctrl to", 32'(obs_ctrl(1)), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // lw, zero wait states
        do_cycle(0, "lw", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "lw", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "lw", 8'd2, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "lw", 8'd3, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "lw", 8'd4, 1'b1, 1'b0, 1'b0);

        bus0.i_opcode = 6'b000000;
        do_cycle(0, "rtype", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "rtype", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "rtype", 8'd6, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "rtype", 8'd7, 1'b1, 1'b0, 1'b0);

        bus0.i_opcode = 6'b000100;
        do_cycle(0, "beq", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "beq", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "beq", 8'd8, 1'b1, 1'b0, 1'b0);

        bus0.i_opcode = 6'b001000;
        do_cycle(0, "addi", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "addi", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "addi", 8'd9, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "addi", 8'd10, 1'b1, 1'b0, 1'b0);

        bus0.i_opcode = 6'b000010;
        do_cycle(0, "j", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "j", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "j", 8'd11, 1'b1, 1'b0, 1'b0);

        // sw with three stalled cycles in MEMWR
        bus0.i_opcode = 6'b101011;
        do_cycle(0, "sw", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "sw", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "sw", 8'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            do_cycle(0, "sw wait", 8'd5, 1'b0, 1'b0, 1'b0);
        do_cycle(0, "sw done", 8'd5, 1'b1, 1'b0, 1'b0);

        bus0.i_opcode = 6'b111111;
        do_cycle(0, "illegal", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "illegal", 8'd1, 1'b1, 1'b1, 1'b0);

        // reset asserted in RTEX
        bus0.i_opcode = 6'b000000;
        do_cycle(0, "rst mid", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "rst mid", 8'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("rst mid pre state", 32'(bus0.o_state), 32'd6);
        #2 rst = 1'b1;
        #1;
        check("rst mid state", 32'(bus0.o_state), 32'd0);
        check("rst mid ctrl", 32'(obs_ctrl(0)), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_cycle(0, "after rst", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "after rst", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(0, "after rst", 8'd6, 1'b1, 1'b0, 1'b0);

        // short-timeout instance, fresh from reset
        rst = 1'b1;
        bus1.i_opcode = 6'b100011;
        @(posedge clk);
        #1 rst = 1'b0;
        do_cycle(1, "to lw", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(1, "to lw", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(1, "to lw", 8'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_cycle(1, "to lw wait", 8'd3, 1'b0, 1'b0, 1'b0);
        do_cycle(1, "to lw abort", 8'd3, 1'b0, 1'b0, 1'b1);
        do_cycle(1, "to after abort", 8'd0, 1'b1, 1'b0, 1'b0);

        // ready arriving on the expiry cycle wins
        bus1.i_opcode = 6'b101011;
        do_cycle(1, "to sw", 8'd1, 1'b1, 1'b0, 1'b0);
        do_cycle(1, "to sw", 8'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_cycle(1, "to sw wait", 8'd5, 1'b0, 1'b0, 1'b0);
        do_cycle(1, "to sw late ready", 8'd5, 1'b1, 1'b0, 1'b0);

        // timeout in FETCH, then counter must be clear for the next fetch
        for (int i = 0; i < 4; i++)
            do_cycle(1, "to fetch wait", 8'd0, 1'b0, 1'b0, 1'b0);
        do_cycle(1, "to fetch abort", 8'd0, 1'b0, 1'b0, 1'b1);
        do_cycle(1, "to fetch retry", 8'd0, 1'b1, 1'b0, 1'b0);
        do_cycle(1, "to fetch retry", 8'd1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
